// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host/device types and command constants
// Used by both the host transmitter and the scan-code receive path.
package ps2_pkg;
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_t;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_ACK          = 8'hFA;
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for the PS/2 clock/data lines plus clock falling-edge pulse
// Registers reset to 1 so an idle (pulled-up) bus never produces a spurious fall.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic sync_clk,
    output logic sync_data,
    output logic fall
);
    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_ff   <= '1;
            data_ff  <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk_in};
            data_ff  <= {data_ff[0], ps2_data_in};
            clk_prev <= clk_ff[1];
        end
    end
    assign sync_clk  = clk_ff[1];
    assign sync_data = data_ff[1];
    assign fall      = clk_prev & ~clk_ff[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter
// Inhibits the bus, issues a start bit, shifts data/parity/stop on device clock falls and checks the ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    ps2_state_t state, state_nxt;
    logic [7:0]    shreg;
    logic          par;
    logic [2:0]    bitcnt;
    logic [IW-1:0] icnt;
    logic [TW-1:0] tcnt;
    logic          ack_ok;
    logic          sync_clk, sync_data, fall;
    logic          inh_last, active, timeout, line_idle;
    ps2_line_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .sync_clk    (sync_clk),
        .sync_data   (sync_data),
        .fall        (fall)
    );
    assign inh_last  = icnt == IW'(INHIBIT_CYCLES - 1);
    assign active    = state inside {START, DATA, PARITY, STOP, ACK, WAIT_IDLE};
    // A fall in the same cycle restarts the budget, so it beats the timeout.
    assign timeout   = active && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign line_idle = sync_clk && sync_data;
    assign tx_ready  = state == IDLE;
    assign busy      = state != IDLE;
    always_comb begin
        state_nxt   = state;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state)
            IDLE:      state_nxt = tx_valid ? INHIBIT : IDLE;
            INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = inh_last;
                state_nxt   = inh_last ? START : INHIBIT;
            end
            START: begin
                ps2_data_oe = 1'b1;
                state_nxt   = fall ? DATA : START;
            end
            DATA: begin
                ps2_data_oe = ~shreg[0];
                state_nxt   = (fall && bitcnt == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
                ps2_data_oe = ~par;
                state_nxt   = fall ? STOP : PARITY;
            end
            STOP:      state_nxt = fall ? ACK : STOP;
            ACK:       state_nxt = WAIT_IDLE;
            WAIT_IDLE: state_nxt = line_idle ? IDLE : WAIT_IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            par     <= 1'b0;
            bitcnt  <= '0;
            icnt    <= '0;
            tcnt    <= '0;
            ack_ok  <= 1'b0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_done <= state == WAIT_IDLE && line_idle && ack_ok && !timeout;
            tx_err  <= timeout || (state == WAIT_IDLE && line_idle && !ack_ok);
            if (state == IDLE && tx_valid) begin
                shreg <= tx_data;
                par   <= ~^tx_data;
            end
            icnt <= state != INHIBIT ? '0 : (icnt == IW'(INHIBIT_CYCLES)) ? icnt : icnt + 1'b1;
            // Held clear through INHIBIT so the budget starts fresh on START entry.
            tcnt <= (state == INHIBIT || fall) ? '0 : (tcnt == TW'(TIMEOUT_CYCLES)) ? tcnt : tcnt + 1'b1;
            if (state == START) bitcnt <= '0;
            if (state == DATA && fall) begin
                bitcnt <= bitcnt + 3'd1;
                shreg  <= shreg >> 1;
            end
            // The 11th fall: device must be holding data low to acknowledge.
            if (state == STOP && fall) ack_ok <= ~sync_data;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-collector PS/2 device model and a frame-level reference model
// The device clocks at 1/20 clk and samples on rising edges.
module tb_ps2_host_tx;
    import ps2_pkg::*;
    logic       clk = 1'b0, reset = 1'b1, tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic       tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err;
    logic       ps2_clk_in, ps2_data_in;
    int         tests = 0, fails = 0;
    int         done_cnt = 0, err_cnt = 0, inh_starts = 0, inh_len = 0, last_inh = 0;
    int         age = 0, end_age = 0;
    bit         in_frame = 1'b0, was;
    logic       prev_doe = 1'b0, prev_coe = 1'b0;
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);
    always #5 clk = ~clk;
    ps2_host_tx #(.INHIBIT_CYCLES(50), .TIMEOUT_CYCLES(400)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask
    // Frame as seen on the wire, first bit in [0]: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction
    // Cycle model: a request taken while idle gives 50 inhibit cycles, start bit on the last one.
    always @(posedge clk) begin
        #1;
        was = in_frame;
        if (reset) in_frame = 1'b0;
        else if (was) begin
            age++;
            if (tx_done || tx_err) begin
                end_age  = age;
                in_frame = 1'b0;
            end
        end else if (tx_valid) begin
            in_frame = 1'b1;
            age      = 0;
        end
        chk("busy", busy, in_frame);
        chk("tx_ready", tx_ready, !in_frame);
        chk("clk_oe", ps2_clk_oe, in_frame && age < 50);
        if (!in_frame || age < 49) chk("data_oe_idle_inhibit", ps2_data_oe, 0);
        else if (age == 49) chk("data_oe_start", ps2_data_oe, 1);
        chk("pulse_exclusive", tx_done && tx_err, 0);
        if (tx_done || tx_err) chk("pulse_in_frame", was, 1);
        if (!reset && ps2_data_oe !== prev_doe && !tx_err) chk("data_change_clk_low", ps2_clk_in, 0);
        if (ps2_clk_oe) begin
            if (!prev_coe) inh_starts++;
            inh_len++;
        end else if (prev_coe) begin
            last_inh = inh_len;
            inh_len  = 0;
        end
        done_cnt += int'(tx_done);
        err_cnt  += int'(tx_err);
        prev_doe = ps2_data_oe;
        prev_coe = ps2_clk_oe;
    end
    task automatic device(input bit ack, input int stop_after, output logic [10:0] got);
        int n = 0;
        got = '0;
        while (!(busy && ps2_clk_in && !ps2_data_in) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("request_to_send_seen", 0, 1);
            return;
        end
        repeat (5) @(negedge clk);
        got[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b0;
            got[i] = ps2_data_in;
            repeat (10) @(negedge clk);
            if (i == stop_after) return;
        end
        dev_data_low = ack;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
    endtask
    task automatic run_frame(input string tag, input logic [7:0] d, input bit ack, input bit hold,
                             input logic [10:0] lit);
        int d0 = done_cnt, e0 = err_cnt, s0 = inh_starts, n = 0;
        logic [10:0] got;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        if (!hold) begin
            @(negedge clk);
            tx_valid = 1'b0;
        end
        device(ack, 0, got);
        while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        chk({tag, "_pulse_seen"}, n < 200, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_bits_model"}, got, frame_bits(d));
        chk({tag, "_bits_literal"}, got, lit);
        chk({tag, "_done_count"}, done_cnt - d0, ack);
        chk({tag, "_err_count"}, err_cnt - e0, !ack);
        chk({tag, "_inhibit_starts"}, inh_starts - s0, 1);
        chk({tag, "_inhibit_len"}, last_inh, 50);
        chk({tag, "_ready_after"}, tx_ready, 1);
        chk({tag, "_busy_after"}, busy, 0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish within time limit");
        $fatal(1);
    end
    initial begin
        int d0, e0, n;
        logic [10:0] part;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_err", tx_err, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        run_frame("ed_ack", PS2_CMD_SET_LEDS, 1'b1, 1'b0, 11'b11111011010);
        run_frame("f4_ack", PS2_CMD_ENABLE, 1'b1, 1'b0, 11'b10111101000);
        run_frame("ff_nack", PS2_CMD_RESET, 1'b0, 1'b0, 11'b11111111110);
        // Device never clocks: timeout 400 cycles after START entry (model age 50).
        d0 = done_cnt;
        e0 = err_cnt;
        n  = 0;
        @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        while (err_cnt == e0 && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk("to_seen", n < 700, 1);
        chk("to_clk_oe", ps2_clk_oe, 0);
        chk("to_data_oe", ps2_data_oe, 0);
        chk("to_ready", tx_ready, 1);
        chk("to_age", end_age, 450);
        repeat (3) @(negedge clk);
        chk("to_err_count", err_cnt - e0, 1);
        chk("to_done_count", done_cnt - d0, 0);
        // Asynchronous reset after the 4th data bit of 0xF4.
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        tx_data  = PS2_CMD_ENABLE;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        device(1'b1, 4, part);
        chk("rr_partial_bits", part[4:0], 5'b01000);
        chk("rr_pre_data_oe", ps2_data_oe, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rr_clk_oe", ps2_clk_oe, 0);
        chk("rr_data_oe", ps2_data_oe, 0);
        chk("rr_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_no_done", done_cnt - d0, 0);
        chk("rr_no_err", err_cnt - e0, 0);
        run_frame("rr_f4", PS2_CMD_ENABLE, 1'b1, 1'b0, 11'b10111101000);
        run_frame("hold_ed", PS2_CMD_SET_LEDS, 1'b1, 1'b1, 11'b11111011010);
        run_frame("second_f4", PS2_CMD_ENABLE, 1'b1, 1'b0, 11'b10111101000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
